// File: rtl/idma_irq_coalescer_if.sv
// Completion / interrupt bus between the iDMA backends, the register
// frontend and the interrupt coalescer.
//   done_i    : per-source single-cycle completion strobes (backend -> coalescer)
//   ack_i     : per-source W1C acknowledge pulses (frontend -> coalescer)
//   en_i      : per-source interrupt enable mask (frontend -> coalescer)
//   irq_o     : per-source interrupt lines (coalescer -> interrupt controller)
//   irq_any_o : OR of irq_o (coalescer -> interrupt controller)
// Source 2c is read-done of channel c, source 2c+1 is write-done of channel c.
interface idma_irq_coalescer_if #(
    parameter int unsigned NumChannels = 4
);
    localparam int unsigned S = 2 * NumChannels;

    logic [S-1:0] done_i;
    logic [S-1:0] ack_i;
    logic [S-1:0] en_i;
    logic [S-1:0] irq_o;
    logic         irq_any_o;

    // Coalescer side
    modport slave (
        input  done_i,
        input  ack_i,
        input  en_i,
        output irq_o,
        output irq_any_o
    );

    // Driver / observer side (backends, frontend, interrupt controller)
    modport master (
        output done_i,
        output ack_i,
        output en_i,
        input  irq_o,
        input  irq_any_o
    );
endinterface

// File: rtl/idma_irq_coalescer.sv
// Per-source completion-interrupt coalescer for multi-channel iDMA.
// Each source counts completion events and raises a sticky pending bit once
// the count reaches the threshold or once the coalescing timer expires.
// Ports:
//   clk_i     : clock, all state updates on the rising edge
//   rst_i     : synchronous active-high reset
//   irq_if    : done/ack/enable inputs and irq outputs (slave modport)
//   thresh_i  : shared event-count threshold (0 behaves as 1)
//   timeout_i : shared coalescing timeout in cycles (0 disables the timer)
//   cnt_o     : per-source event counters, source s at [s*CntWidth +: CntWidth]
//   ovf_o     : sticky per-source counter-saturation flags
module idma_irq_coalescer #(
    parameter int unsigned NumChannels  = 4,
    parameter int unsigned CntWidth     = 8,
    parameter int unsigned TimeoutWidth = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    idma_irq_coalescer_if.slave                  irq_if,
    input  logic [CntWidth-1:0]                  thresh_i,
    input  logic [TimeoutWidth-1:0]              timeout_i,
    output logic [2*NumChannels*CntWidth-1:0]    cnt_o,
    output logic [2*NumChannels-1:0]             ovf_o
);
    localparam int unsigned S = 2 * NumChannels;

    logic [S-1:0][CntWidth-1:0]     cnt_q, cnt_d;
    logic [S-1:0][TimeoutWidth-1:0] tmr_q, tmr_d;
    logic [S-1:0]                   pend_q, pend_d;
    logic [S-1:0]                   ovf_q, ovf_d;

    logic [S-1:0]                   tmr_run;
    logic [S-1:0]                   tmr_hit;
    logic [CntWidth-1:0]            thr_eff;

    always_comb begin
        thr_eff = (thresh_i == '0) ? CntWidth'(1) : thresh_i;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q;
        tmr_run = '0;
        tmr_hit = '0;
        for (int s = 0; s < S; s++) begin
            tmr_run[s] = (cnt_q[s] != '0) && !pend_q[s] && (timeout_i != '0);
            // >= rather than == so that lowering timeout_i below an already
            // elapsed timer still fires instead of stalling forever.
            tmr_hit[s] = tmr_run[s] && (tmr_q[s] >= (timeout_i - TimeoutWidth'(1)));

            if (irq_if.ack_i[s]) begin
                // A strobe colliding with the ack is kept as the first new event.
                cnt_d[s]  = CntWidth'(irq_if.done_i[s]);
                tmr_d[s]  = '0;
                ovf_d[s]  = 1'b0;
                pend_d[s] = irq_if.done_i[s] && (thr_eff == CntWidth'(1));
            end else begin
                if (irq_if.done_i[s]) begin
                    if (&cnt_q[s]) begin
                        ovf_d[s] = 1'b1;
                    end else begin
                        cnt_d[s] = cnt_q[s] + CntWidth'(1);
                    end
                end
                if (tmr_run[s] && !(&tmr_q[s])) begin
                    tmr_d[s] = tmr_q[s] + TimeoutWidth'(1);
                end
                // thr_eff >= 1, so this never fires on an empty counter.
                if ((cnt_d[s] >= thr_eff) || tmr_hit[s]) begin
                    pend_d[s] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            tmr_q  <= '0;
            pend_q <= '0;
            ovf_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            tmr_q  <= tmr_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    assign irq_if.irq_o     = pend_q & irq_if.en_i;
    assign irq_if.irq_any_o = |(pend_q & irq_if.en_i);
    assign cnt_o            = cnt_q;
    assign ovf_o            = ovf_q;

endmodule

// File: tb/tb_idma_irq_coalescer.sv
module tb_idma_irq_coalescer;
    localparam int NCH = 4;
    localparam int S   = 2 * NCH;
    localparam int CW  = 8;
    localparam int TW  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [CW-1:0]     thresh;
    logic [TW-1:0]     timeout;
    logic [S*CW-1:0]   cnt;
    logic [S-1:0]      ovf;

    int vectors   = 0;
    int miscomps  = 0;

    idma_irq_coalescer_if #(.NumChannels(NCH)) u_if ();

    idma_irq_coalescer #(
        .NumChannels (NCH),
        .CntWidth    (CW),
        .TimeoutWidth(TW)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .irq_if   (u_if.slave),
        .thresh_i (thresh),
        .timeout_i(timeout),
        .cnt_o    (cnt),
        .ovf_o    (ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CW-1:0] cnt_of(input int s);
        return cnt[s*CW +: CW];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscomps++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ack_all();
        u_if.ack_i = '1;
        step();
        u_if.ack_i = '0;
    endtask

    initial begin
        rst         = 1'b1;
        thresh      = 8'd1;
        timeout     = '0;
        u_if.done_i = '0;
        u_if.ack_i  = '0;
        u_if.en_i   = '1;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_cnt", 64'(cnt), 64'd0);
        chk("rst_irq", 64'(u_if.irq_o), 64'd0);
        chk("rst_any", 64'(u_if.irq_any_o), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);

        // Threshold: thresh=3, strobes on source 0 in cycles 0, 2, 4
        thresh = 8'd3; timeout = '0; u_if.en_i = '1;
        u_if.done_i = 8'h01; step();            // cycle 1
        u_if.done_i = 8'h00;
        chk("thr_cnt_c1", 64'(cnt_of(0)), 64'd1);
        chk("thr_irq_c1", 64'(u_if.irq_o[0]), 64'd0);
        step();                                 // cycle 2
        u_if.done_i = 8'h01; step();            // cycle 3
        u_if.done_i = 8'h00;
        chk("thr_cnt_c3", 64'(cnt_of(0)), 64'd2);
        step();                                 // cycle 4
        chk("thr_irq_c4", 64'(u_if.irq_o[0]), 64'd0);
        u_if.done_i = 8'h01; step();            // cycle 5
        u_if.done_i = 8'h00;
        chk("thr_cnt_c5", 64'(cnt_of(0)), 64'd3);
        chk("thr_irq_c5", 64'(u_if.irq_o[0]), 64'd1);
        chk("thr_any_c5", 64'(u_if.irq_any_o), 64'd1);
        u_if.ack_i = 8'h01; step();
        u_if.ack_i = 8'h00;
        chk("thr_ack_cnt", 64'(cnt_of(0)), 64'd0);
        chk("thr_ack_any", 64'(u_if.irq_any_o), 64'd0);

        // Timeout: thresh=8, timeout=5, single strobe on source 3 in cycle 0
        thresh = 8'd8; timeout = 16'd5;
        u_if.done_i = 8'h08; step();            // cycle 1
        u_if.done_i = 8'h00;
        chk("tmo_cnt_c1", 64'(cnt_of(3)), 64'd1);
        chk("tmo_irq_c1", 64'(u_if.irq_o[3]), 64'd0);
        step(); step(); step(); step();         // cycle 5
        chk("tmo_irq_c5", 64'(u_if.irq_o[3]), 64'd0);
        step();                                 // cycle 6
        chk("tmo_irq_c6", 64'(u_if.irq_o[3]), 64'd1);
        ack_all();

        // Ack collision: thresh=2, timeout=6, source 1 built up to cnt=4
        thresh = 8'd2; timeout = 16'd6;
        u_if.done_i = 8'h02;
        step(); step(); step(); step();         // cycle 4, four events in
        chk("col_cnt_pre", 64'(cnt_of(1)), 64'd4);
        chk("col_irq_pre", 64'(u_if.irq_o[1]), 64'd1);
        u_if.ack_i = 8'h02;                     // ack + done together in cycle 4
        step();                                 // cycle 5
        u_if.ack_i = 8'h00; u_if.done_i = 8'h00;
        chk("col_cnt", 64'(cnt_of(1)), 64'd1);
        chk("col_irq", 64'(u_if.irq_o[1]), 64'd0);
        // restarted timer: 0 at cycle 5, reaches 5 in cycle 10, irq at 11
        step(); step(); step(); step(); step(); // cycle 10
        chk("col_tmr_c10", 64'(u_if.irq_o[1]), 64'd0);
        step();                                 // cycle 11
        chk("col_tmr_c11", 64'(u_if.irq_o[1]), 64'd1);
        ack_all();

        // Saturation: thresh=255, 300 strobes on source 5
        thresh = 8'd255; timeout = '0;
        u_if.done_i = 8'h20;
        for (int i = 0; i < 255; i++) step();
        chk("sat_cnt_255", 64'(cnt_of(5)), 64'd255);
        chk("sat_ovf_255", 64'(ovf[5]), 64'd0);
        chk("sat_irq_255", 64'(u_if.irq_o[5]), 64'd1);
        for (int i = 0; i < 45; i++) step();
        u_if.done_i = 8'h00;
        chk("sat_cnt", 64'(cnt_of(5)), 64'd255);
        chk("sat_ovf", 64'(ovf[5]), 64'd1);
        chk("sat_irq", 64'(u_if.irq_o[5]), 64'd1);
        u_if.ack_i = 8'h20; step();
        u_if.ack_i = 8'h00;
        chk("sat_ack_cnt", 64'(cnt_of(5)), 64'd0);
        chk("sat_ack_ovf", 64'(ovf[5]), 64'd0);
        chk("sat_ack_irq", 64'(u_if.irq_o[5]), 64'd0);

        // Enable masking: en[2]=0, thresh=1, strobe in cycle 0, enable in cycle 7
        thresh = 8'd1; u_if.en_i = 8'hFB;
        u_if.done_i = 8'h04; step();            // cycle 1
        u_if.done_i = 8'h00;
        chk("en_irq_off", 64'(u_if.irq_o[2]), 64'd0);
        chk("en_any_off", 64'(u_if.irq_any_o), 64'd0);
        chk("en_cnt", 64'(cnt_of(2)), 64'd1);
        for (int i = 0; i < 6; i++) step();     // cycle 7
        chk("en_irq_c7_off", 64'(u_if.irq_o[2]), 64'd0);
        u_if.en_i = 8'hFF;
        #1;
        chk("en_irq_c7_on", 64'(u_if.irq_o[2]), 64'd1);
        ack_all();

        // Threshold 0 behaves as 1
        thresh = 8'd0;
        u_if.done_i = 8'h40; step();
        u_if.done_i = 8'h00;
        chk("thr0_irq", 64'(u_if.irq_o[6]), 64'd1);
        ack_all();

        // Lowering threshold below the count pends without a new event
        thresh = 8'd4;
        u_if.done_i = 8'h01; step(); step();
        u_if.done_i = 8'h00;
        chk("lower_pre", 64'(u_if.irq_o[0]), 64'd0);
        thresh = 8'd2; step();
        chk("lower_irq", 64'(u_if.irq_o[0]), 64'd1);
        ack_all();

        // Reset mid-activity: sources 0 and 7 pending, source 4 counting
        thresh = 8'd2; timeout = '0;
        u_if.done_i = 8'h81; step(); step();
        u_if.done_i = 8'h10; step();
        u_if.done_i = 8'h00;
        chk("rst2_pre_irq", 64'(u_if.irq_o), 64'h81);
        chk("rst2_pre_cnt4", 64'(cnt_of(4)), 64'd1);
        rst = 1'b1; u_if.done_i = 8'h91; u_if.ack_i = 8'h01; step();
        rst = 1'b0; u_if.done_i = 8'h00; u_if.ack_i = 8'h00;
        chk("rst2_cnt", 64'(cnt), 64'd0);
        chk("rst2_irq", 64'(u_if.irq_o), 64'd0);
        chk("rst2_any", 64'(u_if.irq_any_o), 64'd0);
        chk("rst2_ovf", 64'(ovf), 64'd0);
        u_if.done_i = 8'h10; step();
        u_if.done_i = 8'h00;
        chk("rst2_new_cnt", 64'(cnt_of(4)), 64'd1);
        chk("rst2_new_irq", 64'(u_if.irq_o[4]), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomps);
        $finish;
    end
endmodule
